// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw switch source and the debouncer.
// master drives the raw level; slave (the debouncer) returns the debounced level and edge pulses.
interface input_debouncer_if;
    logic i1;
    logic Q;
    logic Q_neg;
    logic rise;
    logic fall;

    modport master (output i1, input Q, Q_neg, rise, fall);
    modport slave  (input i1, output Q, Q_neg, rise, fall);
endinterface

// File: rtl/input_debouncer.sv
// Switch/button debouncer: two-flop synchronizer, four-state stability FSM, optional edge pulses.
// Optional feature macro: DEBOUNCE_EDGE_DETECT_EN (rise/fall pulse registers; tied low when undefined).
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input logic               clk,
    input logic               rst_n,
    input_debouncer_if.slave  dbif
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             q;
    logic [CNT_W-1:0] cnt;
    logic             mismatch_c;
    logic             settle_c;

    // The stable-state entry cycle already counts as the first mismatch cycle,
    // so settle fires when the run of mismatches reaches STABLE_CYCLES.
    always_comb begin
        mismatch_c = 1'b0;
        case (state)
            STABLE_LO, PEND_HI: mismatch_c = sync2;
            STABLE_HI, PEND_LO: mismatch_c = ~sync2;
            default:            mismatch_c = 1'b0;
        endcase
        settle_c = mismatch_c && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
        end else begin
            sync1 <= dbif.i1;
            sync2 <= sync1;
            if (settle_c) begin
                q     <= ~q;
                cnt   <= '0;
                state <= q ? STABLE_LO : STABLE_HI;
            end else if (mismatch_c) begin
                cnt   <= cnt + CNT_W'(1);
                state <= q ? PEND_LO : PEND_HI;
            end else begin
                // Glitch or steady level: drop any partial count.
                cnt   <= '0;
                state <= q ? STABLE_HI : STABLE_LO;
            end
        end
    end

    assign dbif.Q     = q;
    assign dbif.Q_neg = ~q;

`ifdef DEBOUNCE_EDGE_DETECT_EN
    logic rise_r;
    logic fall_r;

    // Pulses line up with the cycle right after Q toggles; reset never emits one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= settle_c & ~q;
            fall_r <= settle_c & q;
        end
    end

    assign dbif.rise = rise_r;
    assign dbif.fall = fall_r;
`else
    assign dbif.rise = 1'b0;
    assign dbif.fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed table, corner sequences, random stimulus vs run-length model.
module tb_input_debouncer;
    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned CNT_W         = 16;
`ifdef DEBOUNCE_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        logic i1;
        logic q;
        logic rise;
        logic fall;
        logic q1;
        logic rise1;
        logic fall1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    input_debouncer_if bif ();
    input_debouncer_if bif1 ();
    assign bif1.i1 = bif.i1;

    input_debouncer #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbif  (bif)
    );

    input_debouncer #(.STABLE_CYCLES(1), .CNT_W(CNT_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .dbif  (bif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: Q flips once the synchronized input has disagreed with Q
    // for STABLE_CYCLES consecutive edges; the synchronizer is a 2-sample delay.
    logic hist[$];
    int   run;
    logic mq;
    logic mrise;
    logic mfall;

    task automatic model_reset();
        hist.delete();
        run   = 0;
        mq    = 1'b0;
        mrise = 1'b0;
        mfall = 1'b0;
    endtask

    task automatic model_edge();
        logic seen;
        seen = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        hist.push_back(bif.i1);
        if (hist.size() > 2) void'(hist.pop_front());
        mrise = 1'b0;
        mfall = 1'b0;
        if (seen != mq) run++;
        else            run = 0;
        if (run == int'(STABLE_CYCLES)) begin
            mq    = ~mq;
            run   = 0;
            mrise = mq;
            mfall = ~mq;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, model update, then sample away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_q",     bif.Q,     mq);
        chk("model_q_neg", bif.Q_neg, ~mq);
        chk("model_rise",  bif.rise,  mrise & EDGE_EN);
        chk("model_fall",  bif.fall,  mfall & EDGE_EN);
        chk("rise_fall_excl", bif.rise & bif.fall, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_q",     bif.Q,      1'b0);
        chk("rst_q_neg", bif.Q_neg,  1'b1);
        chk("rst_rise",  bif.rise,   1'b0);
        chk("rst_fall",  bif.fall,   1'b0);
        chk("rst_q1",    bif1.Q,     1'b0);
        chk("rst_q1_neg", bif1.Q_neg, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    vec_t tbl [20];

    initial begin
        int first_hi;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        bif.i1  = 1'b0;
        model_reset();

        // i1, Q, rise, fall, Q(S=1), rise(S=1), fall(S=1) after each edge from reset
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
        };

        @(posedge clk);
        do_reset();

        // Clean press then release, both depths side by side
        for (int i = 0; i < 20; i++) begin
            bif.i1 = tbl[i].i1;
            step();
            chk($sformatf("tbl%0d_q", i),     bif.Q,      tbl[i].q);
            chk($sformatf("tbl%0d_q_neg", i), bif.Q_neg,  ~tbl[i].q);
            chk($sformatf("tbl%0d_rise", i),  bif.rise,   tbl[i].rise & EDGE_EN);
            chk($sformatf("tbl%0d_fall", i),  bif.fall,   tbl[i].fall & EDGE_EN);
            chk($sformatf("tbl%0d_q1", i),    bif1.Q,     tbl[i].q1);
            chk($sformatf("tbl%0d_q1_neg", i), bif1.Q_neg, ~tbl[i].q1);
            chk($sformatf("tbl%0d_rise1", i), bif1.rise,  tbl[i].rise1 & EDGE_EN);
            chk($sformatf("tbl%0d_fall1", i), bif1.fall,  tbl[i].fall1 & EDGE_EN);
        end

        // Glitch: three high samples are one short of settling
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bif.i1 = (i < 3);
            step();
            chk("glitch_q", bif.Q, 1'b0);
            chk("glitch_rise", bif.rise, 1'b0);
        end

        // Bounce 1,0,1,0,1 then hold: Q rises STABLE_CYCLES+1 edges after the last rising sample
        do_reset();
        first_hi = -1;
        for (int i = 0; i < 16; i++) begin
            bif.i1 = (i >= 4) ? 1'b1 : ((i % 2) == 0);
            step();
            if (bif.Q && first_hi < 0) first_hi = i;
        end
        chk_int("bounce_latency", first_hi, 4 + int'(STABLE_CYCLES) + 1);

        // Fast toggling never settles
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bif.i1 = ~bif.i1;
            step();
            chk("toggle_q", bif.Q, 1'b0);
        end

        // Reset mid-PEND_HI, then full latency from the first post-reset sample
        bif.i1 = 1'b0;
        do_reset();
        bif.i1 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        do_reset();
        first_hi = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bif.Q && first_hi < 0) first_hi = i;
        end
        chk_int("post_reset_latency", first_hi, int'(STABLE_CYCLES) + 1);

        // Reset mid-PEND_LO from Q=1: Q drops immediately, no fall pulse
        bif.i1 = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pend_lo_q_before_rst", bif.Q, 1'b1);
        do_reset();
        step();
        chk("pend_lo_no_fall", bif.fall, 1'b0);

        // Random run-length stimulus with occasional asynchronous resets
        for (int blk = 0; blk < 300; blk++) begin
            int len;
            len = int'($urandom_range(1, 9));
            bif.i1 = ($urandom_range(0, 2) != 0) ? ~bif.i1 : bif.i1;
            for (int k = 0; k < len; k++) step();
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, the consecutive synchronized-mismatch cycles required before Q changes (legal range 1 to 2^CNT_W).
REQ-002 The block SHALL have parameter CNT_W, default 16, the stability counter width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port i1, input, 1, the raw asynchronous data input (switch or button).
REQ-006 The block SHALL have port Q, output, 1, the debounced level, which feeds the downstream D flip-flop data input.
REQ-007 The block SHALL have port Q_neg, output, 1, the complement of Q at all times, including during reset.
REQ-008 The block SHALL have port rise, output, 1, a one-cycle pulse when Q changes 0->1.
REQ-009 The block SHALL have port fall, output, 1, a one-cycle pulse when Q changes 1->0.

Function
REQ-010 i1 SHALL pass through a two-flop synchronizer (sync1, then sync2); only sync2 is used downstream of it.
REQ-011 The FSM SHALL have exactly four states: STABLE_LO, PEND_HI, STABLE_HI and PEND_LO.
REQ-012 The STABLE_LO to PEND_HI transition SHALL occur when sync2=1 while in STABLE_LO; STABLE_HI to PEND_LO SHALL occur when sync2=0 while in STABLE_HI.
REQ-013 In PEND_x, each cycle with sync2 != Q SHALL increment the counter by 1.
REQ-014 In PEND_x, a cycle with sync2 != Q and counter == STABLE_CYCLES-1 SHALL toggle Q, clear the counter and enter the opposite STABLE state.
REQ-015 In PEND_x, a cycle with sync2 == Q (glitch) SHALL clear the counter, return to the originating STABLE state and leave Q unchanged.
REQ-016 Latency: with raw i1 first sampled high at edge 0 and held, Q SHALL go high at edge STABLE_CYCLES+1 (edge 5 at the default).
REQ-017 STABLE_CYCLES=1 SHALL flip Q on the first cycle of mismatch, with no PEND dwell beyond that cycle.
REQ-018 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 rise SHALL be asserted for exactly the one cycle following the edge at which Q becomes 1; fall likewise for Q becoming 0.
REQ-020 rise and fall SHALL never both be 1 in the same cycle.
REQ-021 Continuous toggling of i1 with a period shorter than STABLE_CYCLES cycles SHALL leave Q unchanged indefinitely.
REQ-022 Q, Q_neg, rise and fall SHALL be registered outputs or direct complements of registered outputs.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force sync1=0, sync2=0, counter=0, state=STABLE_LO, Q=0, Q_neg=1, rise=0 and fall=0.
REQ-024 Reset asserted mid-PEND SHALL discard the pending count.
REQ-025 Reset SHALL NOT generate a fall pulse, even if Q was 1.
REQ-026 After rst_n deasserts, the first sample of i1 SHALL be taken at the next rising edge of clk.

Configuration
REQ-027 With macro DEBOUNCE_EDGE_DETECT_EN defined, rise and fall SHALL behave per REQ-019 and REQ-020.
REQ-028 Without DEBOUNCE_EDGE_DETECT_EN, the rise and fall ports SHALL remain present, SHALL be tied to constant 0, and their pulse registers SHALL not be instantiated.
REQ-029 Q and Q_neg behaviour SHALL be identical with and without DEBOUNCE_EDGE_DETECT_EN.

Verification
REQ-030 Clean press: defaults; i1 0->1 and held 20 cycles -> Q=1 and Q_neg=0 at edge 5; rise=1 for that one cycle only; fall stays 0.
REQ-031 Glitch rejection: i1 high for 3 cycles then low -> Q stays 0; rise never asserts; state returns to STABLE_LO.
REQ-032 Bounce then settle: i1 pattern 1,0,1,0,1 (one cycle each), then 1 held -> Q=1 exactly STABLE_CYCLES+1 edges after the final rising sample; no earlier change of Q.
REQ-033 Release: from Q=1, i1 set to 0 and held -> Q=0 at edge 5; fall pulses for one cycle; Q_neg=1.
REQ-034 Reset mid-PEND: defaults; i1 held high; rst_n pulled low after 3 cycles -> Q=0 and Q_neg=1 immediately, with no clock edge; after release with i1 still high -> Q=1 at edge 5 counted from the first post-reset sample.
REQ-035 Macro off: rerun REQ-030 without DEBOUNCE_EDGE_DETECT_EN -> identical Q trace; rise=fall=0 throughout.
